addsub_arb: RTL and testbench
=============================

ADDSUB_ARB -- requirements
Module: addsub_arb

Interface
REQ-001 SHALL have parameter: W, 32, operand/result width in bits.
REQ-002 SHALL have parameter: N, 4, number of requesters (N >= 2); TW = $clog2(N).
REQ-003 SHALL have one clock and an asynchronous, active-low reset:
  clk  input  1  clock, all state on rising edge.
  rstn  input  1  asynchronous active-low reset.
REQ-004 SHALL have the following request-side ports:
  req_valid  input  N  per-requester operation pending.
  req_ready  output  N  one-hot grant, asserted in the accepting cycle.
  req_sub  input  N  per-requester op: 1 = a-b, 0 = a+b.
  req_a  input  N*W  operand A; requester i in bits [i*W +: W].
  req_b  input  N*W  operand B; same packing as req_a.
REQ-005 SHALL have the following response-side ports:
  resp_valid  output  1  result register holds a result.
  resp_ready  input  1  consumer takes the result this cycle.
  resp_tag  output  TW  index of the requester that produced the result.
  resp_data  output  W  a+b or a-b, modulo 2^W.

Function
REQ-006 SHALL contain exactly one shared W-bit ripple-carry add/sub datapath: sum = a + (b XOR {W{sub}}) + sub.
REQ-007 SHALL define take = (|req_valid) & (~resp_valid | resp_ready); no grant is issued when take = 0.
REQ-008 SHALL arbitrate round-robin: when take = 1, grant the first i with req_valid[i] = 1, searching ptr, ptr+1, ... with wrap mod N.
REQ-009 SHALL update ptr to (granted index + 1) mod N on each accept; ptr SHALL hold otherwise.
REQ-010 SHALL drive req_ready as one-hot (granted bit only) when take = 1, and all-zero otherwise; req_ready SHALL be combinational from current inputs and state.
REQ-011 SHALL load resp_data, resp_tag and resp_valid = 1 on the rising edge following an accept (latency: 1 cycle).
REQ-012 SHALL clear resp_valid when resp_ready = 1 and no accept occurs in that cycle.
REQ-013 SHALL, when a drain and an accept occur in the same cycle, replace the register with the new result, keeping resp_valid = 1 (full throughput: 1 op/cycle).
REQ-014 SHALL hold resp_data and resp_tag stable while resp_valid = 1 and resp_ready = 0.
REQ-015 SHALL NOT require req_valid to be sticky; a requester whose req_valid drops before it is granted SHALL simply be skipped.

Reset
REQ-016 SHALL, while rstn = 0, force resp_valid = 0, resp_data = 0, resp_tag = 0 and ptr = 0 asynchronously.
REQ-017 SHALL discard any in-flight result on reset and SHALL issue no grant while rstn = 0.
REQ-018 SHALL accept its first request on the first rising edge of clk after rstn deasserts.

Configuration
REQ-019 SHALL, when ADDSUB_ARB_OVF_EN is defined, add output port resp_ovf (1 bit, reset 0), registered alongside resp_data: signed two's-complement overflow of the selected operation (operand signs equal after B inversion and result sign differs).
REQ-020 SHALL, when ADDSUB_ARB_OVF_EN is undefined, omit the resp_ovf port and its logic entirely, with all other behaviour unchanged.

Verification
REQ-021 Reset: rstn = 0 mid-stream with resp_valid = 1 -> resp_valid = 0 and ptr = 0 immediately; the first post-reset request with all req_valid = 1 is granted to index 0.
REQ-022 Add/sub: req0 with a = 0x0000_0005, b = 0x0000_0007 and sub = 0 -> next cycle resp_data = 0x0000_000C, tag = 0; the same operands with sub = 1 -> 0xFFFF_FFFE.
REQ-023 Round-robin: all four requesters held valid with resp_ready = 1 -> grants 0, 1, 2, 3, 0, ... on consecutive cycles, and tags follow one cycle later.
REQ-024 Backpressure: resp_ready = 0 with resp_valid = 1 -> req_ready = 0 and resp_data/tag frozen; raising resp_ready -> the drain and the next accept occur in the same cycle and resp_valid stays 1.
REQ-025 Wrap/skip: ptr = 3 with only req1 valid -> req1 granted and ptr becomes 2.
REQ-026 Overflow (ADDSUB_ARB_OVF_EN): a = 0x7FFF_FFFF, b = 1, add -> resp_data = 0x8000_0000 and resp_ovf = 1; a = 0x8000_0000, b = 1, sub -> resp_ovf = 1.

Source files
------------

// File: rtl/addsub_arb.sv
// +-----------------------------------------------------------------------------+
// | addsub_arb : N-way round-robin arbiter feeding one shared ripple-carry     |
// |              add/sub datapath with a single registered result slot.        |
// | Optional: define ADDSUB_ARB_OVF_EN to add the registered resp_ovf output.  |
// | Revision: 1.0                                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module addsub_arb #(
  parameter int W  = 32,
  parameter int N  = 4,
  localparam int TW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N-1:0]   req_sub,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [TW-1:0]  resp_tag,
  output logic [W-1:0]   resp_data
`ifdef ADDSUB_ARB_OVF_EN
  ,
  output logic           resp_ovf
`endif
);

  logic [TW-1:0] ptr;
  logic [TW-1:0] ptr_nxt;
  logic [TW-1:0] gnt_idx;
  logic          take;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          op_sub;
  logic [W-1:0]  b_x;
  logic [W-1:0]  carry;
  logic [W-1:0]  sum;

  // Rotating search starting at ptr; first valid requester wins.
  always_comb begin
    logic [TW:0] cand;
    logic        found;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (TW+1)'(k);
      if (cand >= (TW+1)'(N)) cand = cand - (TW+1)'(N);
      if (!found && req_valid[cand[TW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[TW-1:0];
      end
    end
  end

  assign take = rstn & (|req_valid) & (~resp_valid | resp_ready);

  always_comb begin
    req_ready = '0;
    if (take) req_ready[gnt_idx] = 1'b1;
  end

  assign ptr_nxt = (gnt_idx == TW'(N-1)) ? '0 : gnt_idx + 1'b1;

  assign op_a   = req_a[int'(gnt_idx)*W +: W];
  assign op_b   = req_b[int'(gnt_idx)*W +: W];
  assign op_sub = req_sub[gnt_idx];
  assign b_x    = op_b ^ {W{op_sub}};
  assign carry[0] = op_sub;

  generate
    for (genvar i = 0; i < W; i++) begin : g_rca
      assign sum[i] = op_a[i] ^ b_x[i] ^ carry[i];
      if (i < W-1) begin : g_carry
        assign carry[i+1] = (op_a[i] & b_x[i]) | (carry[i] & (op_a[i] ^ b_x[i]));
      end
    end
  endgenerate

`ifdef ADDSUB_ARB_OVF_EN
  logic ovf;
  assign ovf = (op_a[W-1] == b_x[W-1]) & (sum[W-1] != op_a[W-1]);
`endif

  // An accept always overwrites the slot, which covers the same-cycle drain case.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr        <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_tag   <= '0;
`ifdef ADDSUB_ARB_OVF_EN
      resp_ovf   <= 1'b0;
`endif
    end else if (take) begin
      ptr        <= ptr_nxt;
      resp_valid <= 1'b1;
      resp_data  <= sum;
      resp_tag   <= gnt_idx;
`ifdef ADDSUB_ARB_OVF_EN
      resp_ovf   <= ovf;
`endif
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_addsub_arb.sv
// +-----------------------------------------------------------------------------+
// | tb_addsub_arb : directed self-checking bench for addsub_arb (W=32, N=4).   |
// | Revision: 1.0                                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_addsub_arb;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk;
  logic           rstn;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_sub;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           resp_valid;
  logic           resp_ready;
  logic [1:0]     resp_tag;
  logic [W-1:0]   resp_data;
`ifdef ADDSUB_ARB_OVF_EN
  logic           resp_ovf;
`endif

  int checks = 0;
  int errors = 0;

  addsub_arb #(.W(W), .N(N)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sub    (req_sub),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_tag   (resp_tag),
    .resp_data  (resp_data)
`ifdef ADDSUB_ARB_OVF_EN
    ,
    .resp_ovf   (resp_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_sub[i]      = s;
  endtask

  logic [W-1:0] rr_data [4];

  initial begin
    rr_data[0] = 32'h0000_0101;
    rr_data[1] = 32'h0000_0202;
    rr_data[2] = 32'h0000_02FD;
    rr_data[3] = 32'h0000_0404;

    rstn = 1'b0; req_valid = 4'hF; req_sub = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    #2;
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_data",  64'(resp_data),  64'd0);
    chk("rst_tag",   64'(resp_tag),   64'd0);
    chk("rst_no_grant", 64'(req_ready), 64'h0);
    tick(); tick();

    // Release reset; first edge afterwards accepts req0 add.
    rstn = 1'b1; req_valid = 4'b0001;
    set_op(0, 32'h0000_0005, 32'h0000_0007, 1'b0);
    #1;
    chk("first_grant", 64'(req_ready), 64'h1);
    tick();
    chk("add_valid", 64'(resp_valid), 64'd1);
    chk("add_data",  64'(resp_data),  64'h0000_000C);
    chk("add_tag",   64'(resp_tag),   64'd0);

    set_op(0, 32'h0000_0005, 32'h0000_0007, 1'b1);
    #1;
    chk("sub_grant", 64'(req_ready), 64'h1);
    tick();
    chk("sub_data", 64'(resp_data), 64'hFFFF_FFFE);
    chk("sub_tag",  64'(resp_tag),  64'd0);
`ifdef ADDSUB_ARB_OVF_EN
    chk("sub_ovf", 64'(resp_ovf), 64'd0);
`endif

    // Mid-stream reset with a result held.
    resp_ready = 1'b0; req_valid = 4'b0000;
    #1;
    chk("pre_rst_valid", 64'(resp_valid), 64'd1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(resp_valid), 64'd0);
    chk("mid_rst_data",  64'(resp_data),  64'd0);
    req_valid = 4'hF; resp_ready = 1'b1;
    set_op(0, 32'h0000_0100, 32'h0000_0001, 1'b0);
    set_op(1, 32'h0000_0200, 32'h0000_0002, 1'b0);
    set_op(2, 32'h0000_0300, 32'h0000_0003, 1'b1);
    set_op(3, 32'h0000_0400, 32'h0000_0004, 1'b0);
    #1;
    chk("mid_rst_no_grant", 64'(req_ready), 64'h0);
    tick();
    chk("rst_edge_valid", 64'(resp_valid), 64'd0);
    rstn = 1'b1;
    #1;

    // Round-robin with all requesters valid: 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_grant%0d", k), 64'(req_ready), 64'(4'b0001 << (k % 4)));
      tick();
      chk($sformatf("rr_tag%0d", k),  64'(resp_tag),  64'(k % 4));
      chk($sformatf("rr_data%0d", k), 64'(resp_data), 64'(rr_data[k % 4]));
      #1;
    end

    // Backpressure: slot holds tag0/0x101, ptr = 1.
    resp_ready = 1'b0;
    #1;
    chk("bp_no_grant", 64'(req_ready), 64'h0);
    tick(); tick();
    chk("bp_valid", 64'(resp_valid), 64'd1);
    chk("bp_data",  64'(resp_data),  64'h0000_0101);
    chk("bp_tag",   64'(resp_tag),   64'd0);
    resp_ready = 1'b1;
    #1;
    chk("bp_release_grant", 64'(req_ready), 64'b0010);
    tick();
    chk("bp_swap_valid", 64'(resp_valid), 64'd1);
    chk("bp_swap_tag",   64'(resp_tag),   64'd1);
    chk("bp_swap_data",  64'(resp_data),  64'h0000_0202);

    // Drain with no requests.
    req_valid = 4'b0000;
    #1;
    chk("idle_no_grant", 64'(req_ready), 64'h0);
    tick();
    chk("drain_valid", 64'(resp_valid), 64'd0);

    // ptr is 2: grant req2 to move ptr to 3.
    req_valid = 4'b0100;
    #1;
    chk("skip_grant2", 64'(req_ready), 64'b0100);
    tick();
    chk("skip_tag2", 64'(resp_tag), 64'd2);

    // ptr = 3 with only req1 valid: wraps past 3,0 to grant 1.
    req_valid = 4'b0010;
    #1;
    chk("wrap_grant1", 64'(req_ready), 64'b0010);
    tick();
    chk("wrap_tag1",  64'(resp_tag),  64'd1);
    chk("wrap_data1", 64'(resp_data), 64'h0000_0202);

    // ptr should now be 2: req1 and req3 valid -> req3 wins.
    req_valid = 4'b1010;
    #1;
    chk("ptr2_grant3", 64'(req_ready), 64'b1000);
    tick();
    chk("ptr2_tag3", 64'(resp_tag), 64'd3);

    // Signed overflow cases on req0 (ptr = 0).
    req_valid = 4'b0001;
    set_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    #1;
    tick();
    chk("ovf_add_data", 64'(resp_data), 64'h8000_0000);
`ifdef ADDSUB_ARB_OVF_EN
    chk("ovf_add_flag", 64'(resp_ovf), 64'd1);
`endif
    set_op(0, 32'h8000_0000, 32'h0000_0001, 1'b1);
    #1;
    tick();
    chk("ovf_sub_data", 64'(resp_data), 64'h7FFF_FFFF);
`ifdef ADDSUB_ARB_OVF_EN
    chk("ovf_sub_flag", 64'(resp_ovf), 64'd1);
`endif

    req_valid = 4'b0000;
    tick();
    chk("end_valid", 64'(resp_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
